mc_core_ctrl: RTL
=================

Name: mc_core_ctrl

Overview:
Main control FSM for a multi-cycle RV32I core. It sequences a shared datapath: one ALU, one unified memory port, an IR/oldPC latch, an ALUOut register, and the register file `rf`. It decodes opcode/funct fields each instruction and drives the datapath's mux selects and write enables. It also handles memory wait states via a ready handshake, counts retired instructions, and traps on illegal opcodes or memory timeout.

Parameters:
TIMEOUT_CYCLES, 255, maximum consecutive not-ready cycles in a memory state before trapping; 0 disables the timeout.
CNT_W, 32, width of the instret counter.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7_5  in  1  IR[30]
br_taken  in  1  datapath comparator result for funct3 on rs1/rs2
mem_ready  in  1  memory completes the current request this cycle
pc_write  out  1  PC <= selected result
ir_write  out  1  IR <= mem rdata; oldPC <= PC
reg_write  out  1  rf[rd] <= selected result
mem_req  out  1  memory access valid
mem_write  out  1  access is a store (only with mem_req)
adr_src  out  1  memory address: 0 = PC, 1 = selected result
alu_src_a  out  2  0 = PC, 1 = oldPC, 2 = rs1, 3 = zero
alu_src_b  out  2  0 = rs2, 1 = imm, 2 = const 4
result_src  out  2  0 = ALUOut, 1 = mem rdata, 2 = ALU result (comb)
alu_ctrl  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU
trap  out  1  sticky error flag
trap_cause  out  2  0 none, 1 illegal opcode, 2 memory timeout
instret  out  CNT_W  retired-instruction count
state_o  out  4  current state encoding, for debug

Behaviour:
- Outputs are Moore, decoded from state (plus funct fields and ready where noted).
- Any output not listed for a state is 0; `alu_ctrl` defaults to ADD.
- Reset (async, `rst_n` = 0): state = IDLE. `trap` = 0, `trap_cause` = 0, `instret` = 0, timeout counter = 0. All enables are 0 while in reset and in IDLE.
- State encodings: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXER 7, EXEI 8, ALUWB 9, BRANCH 10, JAL 11, JALR 12, LINK 13, EXEU 14, TRAP 15.
- IDLE: go to FETCH next cycle, unconditionally.
- FETCH: `mem_req` = 1, `adr_src` = 0, a = PC, b = 4, ADD, `result_src` = 2. Assert `ir_write` = `pc_write` = `mem_ready`. Stay in FETCH until `mem_ready`, then go to DECODE.
- DECODE: a = oldPC, b = imm, ADD (branch/jal target into ALUOut). Next state by opcode:
  - 0000011 → MEMADR; 0100011 → MEMADR
  - 0110011 → EXER; 0010011 → EXEI
  - 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR
  - 0110111 → EXEU; 0010111 → EXEU
  - anything else → TRAP with cause 1
- MEMADR: a = rs1, b = imm, ADD. Loads go to MEMRD; stores go to MEMWR.
- MEMRD: `mem_req` = 1, `adr_src` = 1, `result_src` = 0. Hold until `mem_ready`, then go to MEMWB.
- MEMWB: `result_src` = 1, `reg_write` = 1. Retire; go to FETCH.
- MEMWR: `mem_req` = 1, `mem_write` = 1, `adr_src` = 1, `result_src` = 0. Hold until `mem_ready`; then retire and go to FETCH.
- EXER: a = rs1, b = rs2. `alu_ctrl` from funct3: 000 ADD/SUB (SUB if `funct7_5`), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (SRA if `funct7_5`), 110 OR, 111 AND. Go to ALUWB.
- EXEI: a = rs1, b = imm, same funct3 map, except 000 is always ADD. `funct7_5` is used only for funct3 = 101. Go to ALUWB.
- EXEU: a = 3 (zero) if `opcode[5]` = 1 (LUI), else a = 1 (oldPC, AUIPC); b = imm, ADD. Go to ALUWB.
- ALUWB: `result_src` = 0, `reg_write` = 1. Retire; go to FETCH.
- BRANCH: a = rs1, b = rs2, SUB, `result_src` = 0, `pc_write` = `br_taken`. Retire; go to FETCH.
- JAL: a = oldPC, b = 4, ADD, `result_src` = 0, `pc_write` = 1. Go to ALUWB.
- JALR: a = rs1, b = imm, ADD, `result_src` = 2, `pc_write` = 1. Go to LINK.
- LINK: a = oldPC, b = 4, ADD. Go to ALUWB.
- Latency with zero wait states, counted from FETCH entry to the next FETCH: load 5, store 4, R/I/U-type 4, branch 3, jal 4, jalr 5.
- Retire: `instret` += 1 (wraps modulo 2^CNT_W) on the cycle leaving MEMWB, ALUWB or BRANCH, and on MEMWR with `mem_ready`. Exactly one increment per instruction.
- Timeout: the counter increments on each cycle spent in FETCH/MEMRD/MEMWR with `mem_ready` = 0, and clears on any state change. When the counter reaches TIMEOUT_CYCLES with `mem_ready` still 0 (and TIMEOUT_CYCLES ≠ 0), go to TRAP with cause 2.
- `mem_ready` on the same cycle the count hits the limit wins: no trap.
- `mem_ready` outside FETCH/MEMRD/MEMWR is ignored.
- TRAP: all enables 0; terminal until reset. `trap` = 1 and `trap_cause` are latched on entry and held.
- Reset asserted mid-instruction (including mid-wait) returns immediately to IDLE. No write enable may be asserted during the reset cycle.

Test Plan:
- Reset release with `mem_ready` = 1 → `state_o` 0 for one cycle, then 1; all enables 0 while `rst_n` = 0; `instret` = 0.
- addi (opcode 0010011, funct3 000) with `mem_ready` = 1 → states 1, 2, 8, 9, 1; `reg_write` = 1 only in state 9; `instret` 0 → 1; `alu_ctrl` = 0 in EXEI.
- lw with `mem_ready` low for 3 cycles in MEMRD → `mem_req` = 1 and `adr_src` = 1 held 4 cycles; no `reg_write` until MEMWB; 8 cycles FETCH-to-FETCH.
- beq: `br_taken` = 1 → `pc_write` = 1 in BRANCH with `result_src` = 0; `br_taken` = 0 → `pc_write` = 0; `instret` +1 in both cases.
- opcode 0000000 → TRAP after DECODE; `trap` = 1, `trap_cause` = 1; no enables thereafter; `instret` unchanged.
- TIMEOUT_CYCLES = 4, `mem_ready` stuck 0 in FETCH → TRAP, `trap_cause` = 2, on the 4th not-ready cycle. Repeat with `mem_ready` = 1 on that cycle → DECODE, no trap. Then assert `rst_n` = 0 mid-MEMWR → IDLE, `mem_write` = 0 at once.

Source files
------------

// File: rtl/mc_core_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mc_core_ctrl_if : decode inputs, datapath controls and status of the     |
// |                   multi-cycle RV32I control FSM.  Rev 1.0                |
// +--------------------------------------------------------------------------+
interface mc_core_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7_5;
  logic             br_taken;
  logic             mem_ready;
  logic             pc_write;
  logic             ir_write;
  logic             reg_write;
  logic             mem_req;
  logic             mem_write;
  logic             adr_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       result_src;
  logic [3:0]       alu_ctrl;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] instret;
  logic [3:0]       state_o;

  modport master (
    input  opcode, funct3, funct7_5, br_taken, mem_ready,
    output pc_write, ir_write, reg_write, mem_req, mem_write, adr_src,
           alu_src_a, alu_src_b, result_src, alu_ctrl,
           trap, trap_cause, instret, state_o
  );

  modport slave (
    output opcode, funct3, funct7_5, br_taken, mem_ready,
    input  pc_write, ir_write, reg_write, mem_req, mem_write, adr_src,
           alu_src_a, alu_src_b, result_src, alu_ctrl,
           trap, trap_cause, instret, state_o
  );
endinterface
`default_nettype wire

// File: rtl/mc_core_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mc_core_ctrl : main control FSM of a multi-cycle RV32I core, with memory |
// |                wait handling, retire counter and trap.  Rev 1.0          |
// +--------------------------------------------------------------------------+
module mc_core_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  mc_core_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXER   = 4'd7,
    S_EXEI   = 4'd8,  S_ALUWB  = 4'd9,  S_BRANCH = 4'd10, S_JAL    = 4'd11,
    S_JALR   = 4'd12, S_LINK   = 4'd13, S_EXEU   = 4'd14, S_TRAP   = 4'd15
  } state_t;

  localparam logic [3:0] C_ADD = 4'd0, C_SUB = 4'd1, C_AND = 4'd2, C_OR  = 4'd3,
                         C_XOR = 4'd4, C_SLL = 4'd5, C_SRL = 4'd6, C_SRA = 4'd7,
                         C_SLT = 4'd8, C_SLTU = 4'd9;
  localparam logic [1:0] C_A_PC = 2'd0, C_A_OLDPC = 2'd1, C_A_RS1 = 2'd2, C_A_ZERO = 2'd3;
  localparam logic [1:0] C_B_RS2 = 2'd0, C_B_IMM = 2'd1, C_B_FOUR = 2'd2;
  localparam logic [1:0] C_R_ALUOUT = 2'd0, C_R_RDATA = 2'd1, C_R_ALU = 2'd2;
  localparam logic [1:0] C_CAUSE_ILL = 2'd1, C_CAUSE_TMO = 2'd2;
  localparam logic [31:0] C_TO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [31:0]      to_cnt_q;
  logic             trap_q;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instret_q;
  logic             in_wait, timeout_hit, retire;

  function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic allow_sub,
                                       input logic f7);
    case (f3)
      3'b000:  f3_op = (allow_sub && f7) ? C_SUB : C_ADD;
      3'b001:  f3_op = C_SLL;
      3'b010:  f3_op = C_SLT;
      3'b011:  f3_op = C_SLTU;
      3'b100:  f3_op = C_XOR;
      3'b101:  f3_op = f7 ? C_SRA : C_SRL;
      3'b110:  f3_op = C_OR;
      default: f3_op = C_AND;
    endcase
  endfunction

  // Timeout fires on the cycle whose not-ready would make the count reach the limit.
  assign in_wait     = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_wait && !bus.mem_ready &&
                       (to_cnt_q == C_TO_LAST);
  assign retire      = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BRANCH) ||
                       ((state_q == S_MEMWR) && bus.mem_ready);

  always_comb begin
    state_d = state_q;
    cause_d = 2'd0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (bus.mem_ready) begin
          state_d = (state_q == S_FETCH) ? S_DECODE :
                    (state_q == S_MEMRD) ? S_MEMWB  : S_FETCH;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = C_CAUSE_TMO;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXER;
          7'b0010011:             state_d = S_EXEI;
          7'b1100011:             state_d = S_BRANCH;
          7'b1101111:             state_d = S_JAL;
          7'b1100111:             state_d = S_JALR;
          7'b0110111, 7'b0010111: state_d = S_EXEU;
          default: begin
            state_d = S_TRAP;
            cause_d = C_CAUSE_ILL;
          end
        endcase
      end
      S_MEMADR: state_d = bus.opcode[5] ? S_MEMWR : S_MEMRD;
      S_MEMWB, S_ALUWB, S_BRANCH: state_d = S_FETCH;
      S_EXER, S_EXEI, S_EXEU, S_JAL, S_LINK: state_d = S_ALUWB;
      S_JALR:   state_d = S_LINK;
      default:  state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      to_cnt_q  <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 2'd0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        to_cnt_q <= '0;
      end else if (in_wait && !bus.mem_ready && (to_cnt_q != '1)) begin
        to_cnt_q <= to_cnt_q + 32'd1;
      end
      if ((state_d == S_TRAP) && (state_q != S_TRAP)) begin
        trap_q  <= 1'b1;
        cause_q <= cause_d;
      end
      if (retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.adr_src    = 1'b0;
    bus.alu_src_a  = C_A_PC;
    bus.alu_src_b  = C_B_RS2;
    bus.result_src = C_R_ALUOUT;
    bus.alu_ctrl   = C_ADD;
    case (state_q)
      S_FETCH: begin
        bus.mem_req    = 1'b1;
        bus.alu_src_b  = C_B_FOUR;
        bus.result_src = C_R_ALU;
        bus.ir_write   = bus.mem_ready;
        bus.pc_write   = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_a = C_A_OLDPC;
        bus.alu_src_b = C_B_IMM;
      end
      S_MEMADR: begin
        bus.alu_src_a = C_A_RS1;
        bus.alu_src_b = C_B_IMM;
      end
      S_MEMRD: begin
        bus.mem_req = 1'b1;
        bus.adr_src = 1'b1;
      end
      S_MEMWB: begin
        bus.result_src = C_R_RDATA;
        bus.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        bus.mem_req   = 1'b1;
        bus.mem_write = 1'b1;
        bus.adr_src   = 1'b1;
      end
      S_EXER: begin
        bus.alu_src_a = C_A_RS1;
        bus.alu_ctrl  = f3_op(bus.funct3, 1'b1, bus.funct7_5);
      end
      S_EXEI: begin
        bus.alu_src_a = C_A_RS1;
        bus.alu_src_b = C_B_IMM;
        bus.alu_ctrl  = f3_op(bus.funct3, 1'b0, bus.funct7_5);
      end
      S_EXEU: begin
        bus.alu_src_a = bus.opcode[5] ? C_A_ZERO : C_A_OLDPC;
        bus.alu_src_b = C_B_IMM;
      end
      S_ALUWB: bus.reg_write = 1'b1;
      S_BRANCH: begin
        bus.alu_src_a = C_A_RS1;
        bus.alu_ctrl  = C_SUB;
        bus.pc_write  = bus.br_taken;
      end
      S_JAL, S_LINK: begin
        bus.alu_src_a = C_A_OLDPC;
        bus.alu_src_b = C_B_FOUR;
        bus.pc_write  = (state_q == S_JAL);
      end
      S_JALR: begin
        bus.alu_src_a  = C_A_RS1;
        bus.alu_src_b  = C_B_IMM;
        bus.result_src = C_R_ALU;
        bus.pc_write   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.trap       = trap_q;
  assign bus.trap_cause = cause_q;
  assign bus.instret    = instret_q;
  assign bus.state_o    = state_q;

endmodule
`default_nettype wire
